// File: rtl/mic_adc_if.sv
// mic_adc_if: pin-level bundle between the microphone ADC front end and its
// surroundings.
//   en         : conversion enable (into the reader)
//   sdata      : ADC serial data (into the reader)
//   cs_n       : ADC chip select, active low (out of the reader)
//   sclk       : ADC serial clock, idles high (out of the reader)
//   adc_data   : last completed 12-bit sample (out of the reader)
//   data_valid : one-cycle strobe when adc_data updates (out of the reader)
//   overrun    : one-cycle strobe when a sample tick is dropped (out of the reader)
//   state_dbg  : current FSM state, for observation only (out of the reader)
// Handshake: there is no back-pressure. data_valid is a single-cycle
// valid-only strobe; the consumer must take adc_data in that cycle or
// read the held value later. Nothing is ever stalled.
interface mic_adc_if;
  logic        en;
  logic        sdata;
  logic        cs_n;
  logic        sclk;
  logic [11:0] adc_data;
  logic        data_valid;
  logic        overrun;
  logic [1:0]  state_dbg;

  modport master (
    input  en,
    input  sdata,
    output cs_n,
    output sclk,
    output adc_data,
    output data_valid,
    output overrun,
    output state_dbg
  );

  modport slave (
    output en,
    output sdata,
    input  cs_n,
    input  sclk,
    input  adc_data,
    input  data_valid,
    input  overrun,
    input  state_dbg
  );
endinterface

// File: rtl/mic_adc_reader.sv
// mic_adc_reader: serial front end for a 12-bit ADCS7476-style microphone ADC.
// Every SAMPLE_DIV clocks a sample tick occurs; if enabled and idle, the block
// lowers cs_n, generates 16 SCLK periods (half-period CLK_DIV clocks), shifts
// sdata in MSB first on each SCLK rising edge, then publishes the low 12 bits
// on adc_data with a one-cycle data_valid strobe, followed by a quiet period.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : mic_adc_if master modport (en, sdata in; cs_n, sclk, adc_data,
//         data_valid, overrun, state_dbg out)
module mic_adc_reader #(
  parameter int CLK_DIV    = 4,
  parameter int SAMPLE_DIV = 6250
) (
  input  logic      clk,
  input  logic      rst,
  mic_adc_if.master bus
);

  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int PW = $clog2(CLK_DIV);
  localparam int QW = $clog2(2 * CLK_DIV);

  localparam logic [TW-1:0] TICK_LAST  = TW'(SAMPLE_DIV - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);
  localparam logic [QW-1:0] QUIET_LAST = QW'(2 * CLK_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CONV  = 2'd1;
  localparam logic [1:0] S_QUIET = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [QW-1:0] quiet_cnt_q, quiet_cnt_d;
  logic [15:0]   shift_q, shift_d;
  logic          cs_n_q, cs_n_d;
  logic          sclk_q, sclk_d;
  logic [11:0]   adc_data_q, adc_data_d;
  logic          data_valid_q, data_valid_d;
  logic          overrun_q, overrun_d;
  logic          tick;

  assign tick = (tick_cnt_q == TICK_LAST);

  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick ? '0 : tick_cnt_q + 1'b1;
    phase_d      = phase_q;
    bit_cnt_d    = bit_cnt_q;
    quiet_cnt_d  = quiet_cnt_q;
    shift_d      = shift_q;
    cs_n_d       = cs_n_q;
    sclk_d       = sclk_q;
    adc_data_d   = adc_data_q;
    data_valid_d = 1'b0;
    overrun_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b1;
        if (tick && bus.en) begin
          state_d   = S_CONV;
          cs_n_d    = 1'b0;
          phase_d   = '0;
          bit_cnt_d = 5'd0;
        end
      end

      S_CONV: begin
        if (tick) overrun_d = 1'b1;
        if (bit_cnt_q == 5'd16) begin
          // Frame complete: the cycle after the 16th rising edge closes it.
          state_d      = S_QUIET;
          cs_n_d       = 1'b1;
          sclk_d       = 1'b1;
          adc_data_d   = shift_q[11:0];
          data_valid_d = 1'b1;
          quiet_cnt_d  = '0;
        end else if (phase_q == PHASE_LAST) begin
          phase_d = '0;
          sclk_d  = ~sclk_q;
          if (!sclk_q) begin
            // SCLK rising: sdata was launched a half period earlier, so it
            // is already stable and is taken without a synchronizer.
            shift_d   = {shift_q[14:0], bus.sdata};
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      S_QUIET: begin
        if (tick) overrun_d = 1'b1;
        if (quiet_cnt_q == QUIET_LAST) state_d = S_IDLE;
        else quiet_cnt_d = quiet_cnt_q + 1'b1;
      end

      default: begin
        state_d = S_IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tick_cnt_q   <= '0;
      phase_q      <= '0;
      bit_cnt_q    <= 5'd0;
      quiet_cnt_q  <= '0;
      shift_q      <= 16'd0;
      cs_n_q       <= 1'b1;
      sclk_q       <= 1'b1;
      adc_data_q   <= 12'd0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      phase_q      <= phase_d;
      bit_cnt_q    <= bit_cnt_d;
      quiet_cnt_q  <= quiet_cnt_d;
      shift_q      <= shift_d;
      cs_n_q       <= cs_n_d;
      sclk_q       <= sclk_d;
      adc_data_q   <= adc_data_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.cs_n       = cs_n_q;
  assign bus.sclk       = sclk_q;
  assign bus.adc_data   = adc_data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.state_dbg  = state_q;

endmodule
